operand_fetch: RTL and testbench

Register-read stage of the RISC-V core, between instruction fetch and execute. It accepts one instruction per cycle over a valid/ready handshake and drives the register file read addresses. It bypasses same-cycle writeback data, tracks in-flight destination registers in a 32-entry scoreboard to stall on RAW hazards, and registers the instruction plus both operands toward execute.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/reg_scoreboard.sv | 54 +++++
 rtl/operand_fetch.sv | 120 ++++++++++++
 tb/tb_operand_fetch.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32 opcode, field and register-use decode helpers
// Purpose: shared opcode constants, register field positions and the
//          source/destination usage decode used by the register-read stage.
// Ports:   none (package).
package riscv_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == LUI || opc == AUIPC || opc == JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OP || opc == STORE || opc == BRANCH);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc, input logic [REG_AW-1:0] rd);
    return (rd != '0) && !(opc == STORE || opc == BRANCH);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight destination register busy tracker
// Purpose: one busy bit per architectural register (x0 never busy). Bits are
//          cleared by writeback, kill and flush, and set by an accepted
//          writer; a set beats a clear of the same register in one cycle.
// Ports:   clk, rst_n           - clock, synchronous active-low reset
//          set_en/set_reg       - accepted instruction writes set_reg
//          clr_en/clr_reg       - writeback commit (also bypassed in lookups)
//          kill_en/kill_reg     - downstream discarded writer
//          flush_en/flush_reg   - flushed held writer
//          rd_addr_1/2, busy_1/2 - combinational busy lookups
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_reg,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic              kill_en,
  input  logic [REG_AW-1:0] kill_reg,
  input  logic              flush_en,
  input  logic [REG_AW-1:0] flush_reg,
  input  logic [REG_AW-1:0] rd_addr_1,
  input  logic [REG_AW-1:0] rd_addr_2,
  output logic              busy_1,
  output logic              busy_2
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // A register committing this cycle is not a hazard: its value is bypassed.
  assign busy_1 = busy[rd_addr_1] && !(clr_en && clr_reg == rd_addr_1);
  assign busy_2 = busy[rd_addr_2] && !(clr_en && clr_reg == rd_addr_2);

  always_comb begin
    busy_nxt = busy;
    if (clr_en)   busy_nxt[clr_reg]   = 1'b0;
    if (kill_en)  busy_nxt[kill_reg]  = 1'b0;
    if (flush_en) busy_nxt[flush_reg] = 1'b0;
    // Set applied last so a new writer survives a same-cycle clear.
    if (set_en)   busy_nxt[set_reg]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage with bypass and RAW stall
// Purpose: accepts one instruction per cycle from fetch, reads the register
//          file, bypasses same-cycle writeback, stalls on busy sources and
//          registers instruction plus operands toward execute.
// Ports:   clk, rst_n                  - clock, synchronous active-low reset
//          in_valid/in_ready/in_instr/in_pc - fetch handshake
//          rd_reg_1/2, rd_data_1/2     - register file read ports
//          wr_en/wr_reg/wr_data        - writeback commit
//          kill_valid/kill_reg         - downstream discarded writer
//          flush                       - drop held output instruction
//          out_valid/out_ready/out_*   - execute handshake and payload
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [31:0]       in_pc,
  output logic [4:0]        rd_reg_1,
  output logic [4:0]        rd_reg_2,
  input  logic [XLEN-1:0]   rd_data_1,
  input  logic [XLEN-1:0]   rd_data_2,
  input  logic              wr_en,
  input  logic [4:0]        wr_reg,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              kill_valid,
  input  logic [4:0]        kill_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic [XLEN-1:0]   out_op_1,
  output logic [XLEN-1:0]   out_op_2
);

  logic [6:0]        in_opc;
  logic [REG_AW-1:0] in_rd;
  logic [6:0]        held_opc;
  logic [REG_AW-1:0] held_rd;
  logic              busy_1;
  logic              busy_2;
  logic              hazard;
  logic              accept;
  logic              flush_clr;
  logic [XLEN-1:0]   op_1;
  logic [XLEN-1:0]   op_2;

  assign in_opc   = in_instr[OPC_LSB +: 7];
  assign in_rd    = in_instr[RD_LSB +: REG_AW];
  assign rd_reg_1 = in_instr[RS1_LSB +: REG_AW];
  assign rd_reg_2 = in_instr[RS2_LSB +: REG_AW];
  assign held_opc = out_instr[OPC_LSB +: 7];
  assign held_rd  = out_instr[RD_LSB +: REG_AW];

  assign hazard   = in_valid && ((uses_rs1(in_opc) && busy_1) ||
                                 (uses_rs2(in_opc) && busy_2));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // A flushed writer never reaches writeback, so release its register here.
  assign flush_clr = flush && out_valid && writes_rd(held_opc, held_rd);

  reg_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (accept && writes_rd(in_opc, in_rd)),
    .set_reg   (in_rd),
    .clr_en    (wr_en),
    .clr_reg   (wr_reg),
    .kill_en   (kill_valid),
    .kill_reg  (kill_reg),
    .flush_en  (flush_clr),
    .flush_reg (held_rd),
    .rd_addr_1 (rd_reg_1),
    .rd_addr_2 (rd_reg_2),
    .busy_1    (busy_1),
    .busy_2    (busy_2)
  );

  always_comb begin
    op_1 = rd_data_1;
    if (rd_reg_1 == '0)                  op_1 = '0;
    else if (wr_en && wr_reg == rd_reg_1) op_1 = wr_data;
  end

  always_comb begin
    op_2 = rd_data_2;
    if (rd_reg_2 == '0)                  op_2 = '0;
    else if (wr_en && wr_reg == rd_reg_2) op_2 = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_op_1  <= '0;
      out_op_2  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      out_op_1  <= op_1;
      out_op_2  <= op_2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - self-checking bench for operand_fetch
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        kill_valid;
  logic [4:0]  kill_reg;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_op_1;
  logic [31:0] out_op_2;

  logic [31:0] rf [32];

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign rd_data_1 = rf[rd_reg_1];
  assign rd_data_2 = rf[rd_reg_2];

  operand_fetch #(.XLEN(32), .NREGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .rd_reg_1   (rd_reg_1),
    .rd_reg_2   (rd_reg_2),
    .rd_data_1  (rd_data_1),
    .rd_data_2  (rd_data_2),
    .wr_en      (wr_en),
    .wr_reg     (wr_reg),
    .wr_data    (wr_data),
    .kill_valid (kill_valid),
    .kill_reg   (kill_reg),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_op_1   (out_op_1),
    .out_op_2   (out_op_2)
  );

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] model_op(input logic [4:0] a);
    if (a == 5'd0)                return 32'h0;
    if (wr_en && wr_reg == a)     return wr_data;
    return rf[a];
  endfunction

  // Output monitor: every completed output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got instr=%h pc=%h, required no output", out_instr, out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_instr !== mon_e.instr || out_pc !== mon_e.pc ||
            out_op_1 !== mon_e.op1 || out_op_2 !== mon_e.op2) begin
          errors++;
          $display("FAIL sb_output: got instr=%h pc=%h op1=%h op2=%h, required instr=%h pc=%h op1=%h op2=%h",
                   out_instr, out_pc, out_op_1, out_op_2, mon_e.instr, mon_e.pc, mon_e.op1, mon_e.op2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_instr   = 32'h0;
    in_pc      = 32'h0;
    wr_en      = 1'b0;
    wr_reg     = 5'd0;
    wr_data    = 32'h0;
    kill_valid = 1'b0;
    kill_reg   = 5'd0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Present an instruction, wait for acceptance and check the stall length.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input int exp_wait, input string name);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (n != exp_wait) begin
      errors++;
      $display("FAIL %s_wait: got %0d stall cycles, required %0d", name, n, exp_wait);
    end
    if (in_ready === 1'b1) begin
      exp_q.push_back('{instr, pc, model_op(instr[19:15]), model_op(instr[24:20])});
      @(posedge clk);
      #1;
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b0;
    issue(i_addi(5'd1, 5'd0, 12'd9), 32'h40, 0, "reset_pre");
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (dut.u_scoreboard.busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h, required 0", dut.u_scoreboard.busy); end
    checks++;
    if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_op_1 !== 32'h0 || out_op_2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_payload: got %h %h %h %h, required all 0", out_instr, out_pc, out_op_1, out_op_2);
    end
  endtask

  task automatic test_independent();
    do_reset();
    issue(i_addi(5'd1, 5'd0, 12'd5), 32'h100, 0, "indep_addi");
    issue(r_add(5'd3, 5'd2, 5'd4), 32'h104, 0, "indep_add");
    checks++;
    if (out_op_1 !== 32'h11 || out_op_2 !== 32'h22) begin
      errors++;
      $display("FAIL indep_ops: got %h/%h, required 00000011/00000022", out_op_1, out_op_2);
    end
    tick();
  endtask

  task automatic test_raw();
    do_reset();
    issue(i_addi(5'd5, 5'd0, 12'd7), 32'h200, 0, "raw_writer");
    in_valid = 1'b1;
    in_instr = r_add(5'd6, 5'd5, 5'd5);
    in_pc    = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: cycle %0d got in_ready %b, required 0", i, in_ready); end
      tick();
    end
    wr_en   = 1'b1;
    wr_reg  = 5'd5;
    wr_data = 32'd7;
    issue(r_add(5'd6, 5'd5, 5'd5), 32'h204, 0, "raw_release");
    wr_en = 1'b0;
    rf[5] = 32'd7;
    checks++;
    if (out_op_1 !== 32'd7 || out_op_2 !== 32'd7) begin
      errors++;
      $display("FAIL raw_bypass: got %h/%h, required 00000007/00000007", out_op_1, out_op_2);
    end
    checks++;
    if (dut.u_scoreboard.busy[5] !== 1'b0 || dut.u_scoreboard.busy[6] !== 1'b1) begin
      errors++;
      $display("FAIL raw_busy: got busy5=%b busy6=%b, required 0/1", dut.u_scoreboard.busy[5], dut.u_scoreboard.busy[6]);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    issue(i_addi(5'd1, 5'd0, 12'd1), 32'h300, 0, "bp_first");
    in_valid = 1'b1;
    in_instr = i_addi(5'd2, 5'd0, 12'd2);
    in_pc    = 32'h304;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== i_addi(5'd1, 5'd0, 12'd1) || out_pc !== 32'h300) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got in_ready=%b valid=%b instr=%h pc=%h, required 0/1/%h/00000300",
                 i, in_ready, out_valid, out_instr, out_pc, i_addi(5'd1, 5'd0, 12'd1));
      end
      tick();
    end
    out_ready = 1'b1;
    issue(i_addi(5'd2, 5'd0, 12'd2), 32'h304, 0, "bp_second");
    issue(i_addi(5'd3, 5'd0, 12'd3), 32'h308, 0, "bp_third");
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    issue(r_add(5'd0, 5'd1, 5'd2), 32'h400, 0, "x0_writer");
    wr_en   = 1'b1;
    wr_reg  = 5'd0;
    wr_data = 32'hDEAD;
    issue(r_add(5'd7, 5'd0, 5'd0), 32'h404, 0, "x0_reader");
    wr_en = 1'b0;
    checks++;
    if (out_op_1 !== 32'h0 || out_op_2 !== 32'h0) begin
      errors++;
      $display("FAIL x0_ops: got %h/%h, required 0/0", out_op_1, out_op_2);
    end
    checks++;
    if (dut.u_scoreboard.busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b, required 0", dut.u_scoreboard.busy[0]); end
    tick();
  endtask

  task automatic test_flush_kill();
    do_reset();
    out_ready = 1'b0;
    issue(i_addi(5'd9, 5'd0, 12'd1), 32'h500, 0, "flush_writer");
    checks++;
    if (dut.u_scoreboard.busy[9] !== 1'b1) begin errors++; $display("FAIL flush_busy_set: got %b, required 1", dut.u_scoreboard.busy[9]); end
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b, required 0", in_ready); end
    tick();
    flush = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_valid !== 1'b0 || dut.u_scoreboard.busy[9] !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got valid=%b busy9=%b, required 0/0", out_valid, dut.u_scoreboard.busy[9]);
    end
    issue(r_add(5'd11, 5'd9, 5'd9), 32'h504, 0, "flush_reader");

    issue(i_addi(5'd10, 5'd0, 12'd2), 32'h508, 0, "kill_writer");
    in_valid   = 1'b1;
    in_instr   = r_add(5'd12, 5'd10, 5'd10);
    in_pc      = 32'h50C;
    kill_valid = 1'b1;
    kill_reg   = 5'd10;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL kill_same_cycle: got in_ready %b, required 0", in_ready); end
    tick();
    kill_valid = 1'b0;
    issue(r_add(5'd12, 5'd10, 5'd10), 32'h50C, 0, "kill_reader");

    issue(i_addi(5'd13, 5'd0, 12'd3), 32'h510, 0, "setwin_first");
    wr_en   = 1'b1;
    wr_reg  = 5'd13;
    wr_data = 32'h5;
    issue(i_addi(5'd13, 5'd0, 12'd4), 32'h514, 0, "setwin_second");
    wr_en = 1'b0;
    checks++;
    if (dut.u_scoreboard.busy[13] !== 1'b1) begin errors++; $display("FAIL set_wins: got busy13=%b, required 1", dut.u_scoreboard.busy[13]); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    issue(i_addi(5'd5, 5'd0, 12'd1), 32'h600, 0, "mid_writer");
    in_valid = 1'b1;
    in_instr = r_add(5'd6, 5'd5, 5'd5);
    in_pc    = 32'h604;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_stall: got in_ready %b, required 0", in_ready); end
    tick();
    do_reset();
    checks++;
    if (dut.u_scoreboard.busy !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%h valid=%b, required 0/0", dut.u_scoreboard.busy, out_valid);
    end
    issue(r_add(5'd6, 5'd5, 5'd5), 32'h604, 0, "mid_reader");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'hBAD0;
    rf[2] = 32'h11;
    rf[4] = 32'h22;
    do_reset();
    test_reset();
    test_independent();
    test_raw();
    test_backpressure();
    test_x0();
    test_flush_kill();
    test_reset_mid_stall();
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
